fifo_uart_tx: RTL and testbench

//   Read-side consumer of async_fifo, in the rd_clk domain. Pops one byte per

---
 rtl/fifo_uart_tx.sv | 114 +++++++++++
 tb/tb_fifo_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains an async_fifo read port and serialises each byte as UART 8N1, LSB first.
// Frames run back-to-back while the FIFO stays non-empty; tx_count tracks completed frames.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               rd_clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_dout,
  output logic               fifo_rd_en,
  output logic               tx,
  output logic               busy,
  output logic [COUNT_W-1:0] tx_count
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q;
  logic [BW-1:0]      baud_q;
  logic [2:0]         bit_q;
  logic [7:0]         shreg_q;
  logic               tx_q;
  logic [COUNT_W-1:0] count_q;

  logic baud_done;
  assign baud_done = (baud_q == BAUD_LAST);

  // tx_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!fifo_empty) state_q <= S_POP;
        end
        S_POP: begin
          baud_q  <= '0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          baud_q  <= '0;
          shreg_q <= fifo_dout;
          tx_q    <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q  <= '0;
            shreg_q <= shreg_q >> 1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_q  <= '0;
            count_q <= count_q + 1'b1;
            state_q <= fifo_empty ? S_IDLE : S_POP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = (state_q == S_POP);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign tx_count   = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO feeding the DUT, and a sampling UART
// receiver that decodes tx and compares against the pushed byte stream.
module tb_fifo_uart_tx;

  localparam int CPB     = 4;
  localparam int COUNT_W = 4;
  localparam int LIMIT   = 200;

  logic               rd_clk = 1'b0;
  logic               rst = 1'b1;
  logic               fifo_empty = 1'b1;
  logic [7:0]         fifo_dout = '0;
  logic               fifo_rd_en;
  logic               tx;
  logic               busy;
  logic [COUNT_W-1:0] tx_count;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int underflows = 0;
  int exp_count = 0;
  logic [7:0] fq[$];

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .COUNT_W     (COUNT_W)
  ) dut (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_count  (tx_count)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: read data appears one cycle after the pop strobe.
  always @(posedge rd_clk) begin
    if (fifo_rd_en === 1'b1) begin
      pops++;
      if (fifo_empty || fq.size() == 0) begin
        underflows++;
      end else begin
        fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Waits for a start bit, then captures a whole frame cycle by cycle. Returns
  // at the negedge of the last stop cycle; pre = high cycles seen before start.
  task automatic recv_frame(output logic [7:0] data, output logic [9:0] bits,
                            output bit ok, output int pre);
    logic s [0:10*CPB-1];
    bit found;
    found = 0; ok = 0; pre = 0; data = '0; bits = '0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge rd_clk);
      if (tx === 1'b0) begin
        found = 1;
        break;
      end
      pre++;
    end
    if (!found) return;
    s[0] = tx;
    for (int c = 1; c < 10*CPB; c++) begin
      @(negedge rd_clk);
      s[c] = tx;
    end
    ok = 1;
    for (int b = 0; b < 10; b++) begin
      bits[b] = s[b*CPB + CPB/2];
      for (int k = 0; k < CPB; k++)
        if (s[b*CPB + k] !== bits[b]) ok = 0;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 0;
    data = bits[8:1];
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    checks++;
    if (tx_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", tx_count); end
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_idle_empty();
    int bad_rd, bad_tx, bad_busy;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge rd_clk);
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_rd != 0) begin errors++; $display("FAIL idle_rd_en got %0d high cycles exp 0", bad_rd); end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL idle_tx got %0d low cycles exp 0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL idle_busy got %0d busy cycles exp 0", bad_busy); end
    checks++;
    if (tx_count !== '0) begin errors++; $display("FAIL idle_count got %0d exp 0", tx_count); end
  endtask

  task automatic test_single();
    logic [7:0] d; logic [9:0] bits; bit ok; int pre, p0;
    logic [9:0] exp_bits;
    exp_bits = 10'b11_0100_1010;
    p0 = pops;
    push(8'hA5);
    @(negedge rd_clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL lat_pop got %b exp 1", fifo_rd_en); end
    @(negedge rd_clk);
    checks++;
    if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL lat_load got rd_en=%b tx=%b busy=%b exp 0 1 1", fifo_rd_en, tx, busy); end
    recv_frame(d, bits, ok, pre);
    checks++;
    if (pre != 0) begin errors++; $display("FAIL lat_start got %0d extra cycles exp 0", pre); end
    checks++;
    if (!ok) begin errors++; $display("FAIL a5_framing got bits %b exp %b", bits, exp_bits); end
    checks++;
    if (bits !== exp_bits) begin errors++; $display("FAIL a5_bits got %b exp %b", bits, exp_bits); end
    @(negedge rd_clk);
    exp_count = (exp_count + 1) % (1 << COUNT_W);
    checks++;
    if (tx_count !== COUNT_W'(exp_count)) begin errors++; $display("FAIL a5_count got %0d exp %0d", tx_count, exp_count); end
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL a5_pops got %0d exp 1", pops - p0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic [9:0] bits; bit ok; int pre, p0;
    int bad_data, bad_frame, bad_gap;
    bad_data = 0; bad_frame = 0; bad_gap = 0;
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 1; i <= 8; i++) begin
      recv_frame(d, bits, ok, pre);
      if (!ok) bad_frame++;
      if (d !== 8'(i)) begin
        bad_data++;
        $display("FAIL b2b_byte%0d got %h exp %h", i, d, 8'(i));
      end
      if (i > 1 && pre + CPB != CPB + 2) begin
        bad_gap++;
        $display("FAIL b2b_gap%0d got %0d exp %0d", i, pre + CPB, CPB + 2);
      end
      exp_count = (exp_count + 1) % (1 << COUNT_W);
    end
    checks++;
    if (bad_data != 0) begin errors++; $display("FAIL b2b_data got %0d bad exp 0", bad_data); end
    checks++;
    if (bad_frame != 0) begin errors++; $display("FAIL b2b_framing got %0d bad exp 0", bad_frame); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_gaps got %0d bad exp 0", bad_gap); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_stop got %b exp 1", busy); end
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0)
      begin errors++; $display("FAIL b2b_busy_end got busy=%b rd_en=%b exp 0 0", busy, fifo_rd_en); end
    checks++;
    if (tx_count !== COUNT_W'(exp_count)) begin errors++; $display("FAIL b2b_count got %0d exp %0d", tx_count, exp_count); end
    checks++;
    if (pops - p0 != 8) begin errors++; $display("FAIL b2b_pops got %0d exp 8", pops - p0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b1, b2, d; logic [9:0] bits; bit ok, found; int pre, p0, lows;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    p0 = pops;
    push(b1);
    push(b2);
    found = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge rd_clk);
      if (tx === 1'b0) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_start got no start bit exp start within %0d", LIMIT); end
    // Move to mid data bit 3 (frame bit 4).
    repeat (4*CPB + 1) @(negedge rd_clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got tx=%b busy=%b rd_en=%b exp 1 0 0", tx, busy, fifo_rd_en); end
    repeat (2) @(negedge rd_clk);
    rst = 1'b0;
    exp_count = 0;
    checks++;
    if (tx_count !== '0) begin errors++; $display("FAIL rstmid_count0 got %0d exp 0", tx_count); end
    recv_frame(d, bits, ok, pre);
    checks++;
    if (!ok || d !== b2) begin errors++; $display("FAIL rstmid_next got %h ok=%0d exp %h", d, ok, b2); end
    exp_count = 1;
    lows = 0;
    for (int i = 0; i < 10*CPB*2; i++) begin
      @(negedge rd_clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rstmid_resend got %0d low cycles exp 0", lows); end
    checks++;
    if (tx_count !== COUNT_W'(exp_count)) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", tx_count, exp_count); end
    checks++;
    if (pops - p0 != 2) begin errors++; $display("FAIL rstmid_pops got %0d exp 2", pops - p0); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$]; logic [7:0] d, e; logic [9:0] bits; bit ok; int pre;
    rst = 1'b1;
    @(negedge rd_clk);
    rst = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 17; i++) begin
      e = 8'($urandom_range(0, 255));
      exp_q.push_back(e);
      push(e);
    end
    for (int i = 1; i <= 17; i++) begin
      recv_frame(d, bits, ok, pre);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL wrap_byte%0d got %h ok=%0d exp %h", i, d, ok, e); end
      @(negedge rd_clk);
      exp_count = (exp_count + 1) % (1 << COUNT_W);
      if (i >= 15) begin
        checks++;
        if (tx_count !== COUNT_W'(exp_count))
          begin errors++; $display("FAIL wrap_count%0d got %h exp %h", i, tx_count, exp_count); end
      end
    end
  endtask

  task automatic test_empty_at_last_stop();
    logic [7:0] x, y, d; logic [9:0] bits; bit ok; int pre;
    x = 8'($urandom_range(0, 255));
    y = 8'($urandom_range(0, 255));
    repeat (3) @(negedge rd_clk);
    push(x);
    recv_frame(d, bits, ok, pre);
    checks++;
    if (!ok || d !== x) begin errors++; $display("FAIL laststop_first got %h ok=%0d exp %h", d, ok, x); end
    push(y);
    @(negedge rd_clk);
    checks++;
    if (fifo_rd_en !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL laststop_pop got rd_en=%b busy=%b exp 1 1", fifo_rd_en, busy); end
    recv_frame(d, bits, ok, pre);
    checks++;
    if (!ok || d !== y || pre != 1)
      begin errors++; $display("FAIL laststop_second got %h ok=%0d pre=%0d exp %h pre=1", d, ok, pre, y); end
    @(negedge rd_clk);
    checks++;
    if (underflows != 0) begin errors++; $display("FAIL underflow got %0d pops on empty exp 0", underflows); end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    test_empty_at_last_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
